// File: rtl/riscv_lsu.sv
// Load/store unit: issues one req/gnt/rvalid data-memory transaction at a time,
// generates byte lanes and store data, and aligns and extends returned load data.
module riscv_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  input  logic              req_wr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_zero_ext_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              req_ready_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              zext_q, zext_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              misalign_q, misalign_d;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   lane_wdata = {4{wdata[7:0]}};
      2'b01:   lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic zext,
                                              input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] s;
    s = rdata >> {off, 3'b000};
    case (size)
      2'b00:   load_extend = zext ? {24'h000000, s[7:0]} : {{24{s[7]}}, s[7:0]};
      2'b01:   load_extend = zext ? {16'h0000, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: load_extend = rdata;
    endcase
  endfunction

  assign req_ready_o  = (state_q == IDLE);
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign misalign_o   = misalign_q;

  // Next-state and response decode; the dmem request register mirrors entry into REQ.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    off_d       = off_q;
    zext_d      = zext_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    misalign_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
            rsp_valid_d = 1'b1;
            misalign_d  = 1'b1;
          end else begin
            state_d = REQ;
            we_d    = req_wr_i;
            addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
            be_d    = lane_be(req_size_i, req_addr_i[1:0]);
            wdata_d = lane_wdata(req_size_i, req_wdata_i);
            size_d  = req_size_i;
            off_d   = req_addr_i[1:0];
            zext_d  = req_zero_ext_i;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          if (we_q) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_extend(size_q, zext_q, off_q, dmem_rdata_i);
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  // State, transaction and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0000_0000;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      zext_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      off_q       <= off_d;
      zext_q      <= zext_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      misalign_q  <= misalign_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboarded bench for riscv_lsu: tests push expected responses, a monitor pops
// and compares them on each rsp_valid_o pulse.
module tb_riscv_lsu;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_wr, req_zext;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic          dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [3:0]    dmem_be;
  logic [31:0]   dmem_wdata;
  logic          dmem_gnt, dmem_rvalid;
  logic [31:0]   dmem_rdata;
  logic          rsp_valid, misalign;
  logic [31:0]   rsp_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int last_rsp_cyc = 0;
  logic [32:0] exp_q[$];

  // observations recorded by the access driver
  int            t_acc;
  logic          ready_at_req, req_seen, stable_ok, ready_low_ok;
  logic          obs_we;
  logic [AW-1:0] obs_addr;
  logic [3:0]    obs_be;
  logic [31:0]   obs_wdata;

  riscv_lsu #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_wr_i(req_wr), .req_size_i(req_size),
    .req_zero_ext_i(req_zext), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .misalign_o(misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // response monitor: every pulse must match the oldest expected response
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      logic [32:0] e;
      rsp_cnt++;
      last_rsp_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got misalign=%b rdata=%h, required no response", misalign, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({misalign, rsp_rdata} !== e) begin
          failures++;
          $display("FAIL rsp_data: got misalign=%b rdata=%h, required misalign=%b rdata=%h",
                   misalign, rsp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic access(input logic wr, input logic [1:0] size, input logic zext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit expect_mem, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input bit tail);
    logic [68:0] snap;
    @(negedge clk);
    ready_at_req = req_ready;
    req_valid = 1'b1; req_wr = wr; req_size = size; req_zext = zext;
    req_addr = addr; req_wdata = wdata;
    t_acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_seen = 1'b0; stable_ok = 1'b1; ready_low_ok = 1'b1;
    if (!expect_mem) begin
      repeat (3) begin
        @(negedge clk);
        if (dmem_req !== 1'b0) req_seen = 1'b1;
      end
    end else begin
      @(negedge clk);
      snap = {dmem_we, dmem_addr, dmem_be, dmem_wdata};
      for (int i = 0; i < gnt_dly; i++) begin
        if (dmem_req !== 1'b1 || {dmem_we, dmem_addr, dmem_be, dmem_wdata} !== snap) stable_ok = 1'b0;
        if (req_ready !== 1'b0) ready_low_ok = 1'b0;
        @(negedge clk);
      end
      if (dmem_req !== 1'b1 || {dmem_we, dmem_addr, dmem_be, dmem_wdata} !== snap) stable_ok = 1'b0;
      if (req_ready !== 1'b0) ready_low_ok = 1'b0;
      obs_we = dmem_we; obs_addr = dmem_addr; obs_be = dmem_be; obs_wdata = dmem_wdata;
      dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      if (!wr) begin
        for (int i = 0; i <= rv_dly; i++) begin
          @(negedge clk);
          if (dmem_req !== 1'b0) stable_ok = 1'b0;
          if (req_ready !== 1'b0) ready_low_ok = 1'b0;
        end
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0; dmem_rdata = 32'hBAD0_BAD0;
      end
    end
    if (tail) repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_zext = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, rsp_valid, rsp_rdata, misalign} !== 104'h0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wdata=%h rv=%b rd=%h mis=%b, required all 0",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, rsp_valid, rsp_rdata, misalign);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b, required 1", req_ready);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_store;
    int c0;
    c0 = rsp_cnt;
    exp_q.push_back({1'b0, 32'h0000_0000});
    access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1, 0, 0, 32'h0, 1'b1);
    checks++;
    if ({obs_we, obs_addr, obs_be, obs_wdata} !== {1'b1, 32'h100, 4'b1111, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL word_store_port: got we=%b addr=%h be=%b wdata=%h, required we=1 addr=00000100 be=1111 wdata=deadbeef",
               obs_we, obs_addr, obs_be, obs_wdata);
    end
    checks++;
    if (rsp_cnt - c0 != 1 || last_rsp_cyc - t_acc != 2) begin
      failures++;
      $display("FAIL word_store_latency: got pulses=%0d latency=%0d, required pulses=1 latency=2",
               rsp_cnt - c0, last_rsp_cyc - t_acc);
    end
  endtask

  task automatic test_byte_store;
    exp_q.push_back({1'b0, 32'h0000_0000});
    access(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, 1'b1, 0, 0, 32'h0, 1'b1);
    checks++;
    if ({obs_we, obs_addr, obs_be, obs_wdata} !== {1'b1, 32'h100, 4'b1000, 32'hA5A5_A5A5}) begin
      failures++;
      $display("FAIL byte_store_port: got we=%b addr=%h be=%b wdata=%h, required we=1 addr=00000100 be=1000 wdata=a5a5a5a5",
               obs_we, obs_addr, obs_be, obs_wdata);
    end
  endtask

  task automatic test_byte_load;
    exp_q.push_back({1'b0, 32'hFFFF_FFF0});
    access(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 1'b1, 0, 0, 32'h12F0_3456, 1'b1);
    checks++;
    if ({obs_we, obs_addr, obs_be} !== {1'b0, 32'h100, 4'b0100}) begin
      failures++;
      $display("FAIL byte_load_port: got we=%b addr=%h be=%b, required we=0 addr=00000100 be=0100",
               obs_we, obs_addr, obs_be);
    end
    checks++;
    if (last_rsp_cyc - t_acc != 3) begin
      failures++; $display("FAIL byte_load_latency: got %0d, required 3", last_rsp_cyc - t_acc);
    end
    exp_q.push_back({1'b0, 32'h0000_00F0});
    access(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 1'b1, 0, 0, 32'h12F0_3456, 1'b1);
  endtask

  task automatic test_half_load_stall;
    int c0;
    c0 = rsp_cnt;
    exp_q.push_back({1'b0, 32'hFFFF_8001});
    access(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 1'b1, 3, 2, 32'h8001_ABCD, 1'b1);
    checks++;
    if ({obs_addr, obs_be} !== {32'h200, 4'b1100}) begin
      failures++;
      $display("FAIL half_load_port: got addr=%h be=%b, required addr=00000200 be=1100", obs_addr, obs_be);
    end
    checks++;
    if (stable_ok !== 1'b1 || ready_low_ok !== 1'b1) begin
      failures++;
      $display("FAIL half_load_stall: got stable=%b ready_low=%b, required 1 1", stable_ok, ready_low_ok);
    end
    checks++;
    if (rsp_cnt - c0 != 1 || last_rsp_cyc - t_acc != 8) begin
      failures++;
      $display("FAIL half_load_latency: got pulses=%0d latency=%0d, required pulses=1 latency=8",
               rsp_cnt - c0, last_rsp_cyc - t_acc);
    end
  endtask

  task automatic test_misaligned;
    logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] addrs [3] = '{32'h101, 32'h003, 32'h000};
    for (int k = 0; k < 3; k++) begin
      int c0;
      c0 = rsp_cnt;
      exp_q.push_back({1'b1, 32'h0000_0000});
      access(1'b0, sizes[k], 1'b0, addrs[k], 32'h0, 1'b0, 0, 0, 32'h0, 1'b0);
      checks++;
      if (rsp_cnt - c0 != 1 || last_rsp_cyc - t_acc != 1 || req_seen !== 1'b0) begin
        failures++;
        $display("FAIL misaligned_%0d: got pulses=%0d latency=%0d dmem_req_seen=%b, required 1 1 0",
                 k, rsp_cnt - c0, last_rsp_cyc - t_acc, req_seen);
      end
    end
  endtask

  task automatic test_back_to_back;
    int t_first, c0;
    c0 = rsp_cnt;
    exp_q.push_back({1'b0, 32'h1122_3344});
    exp_q.push_back({1'b0, 32'h0000_00BA});
    access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b1, 0, 0, 32'h1122_3344, 1'b0);
    t_first = t_acc;
    access(1'b0, 2'b00, 1'b1, 32'h301, 32'h0, 1'b1, 0, 0, 32'hCAFE_BA98, 1'b1);
    checks++;
    if (ready_at_req !== 1'b1 || t_acc - t_first != 3) begin
      failures++;
      $display("FAIL b2b_accept: got ready=%b accept_gap=%0d, required ready=1 accept_gap=3",
               ready_at_req, t_acc - t_first);
    end
    checks++;
    if (rsp_cnt - c0 != 2) begin
      failures++; $display("FAIL b2b_pulses: got %0d, required 2", rsp_cnt - c0);
    end
  endtask

  task automatic test_reset_mid;
    int c0;
    c0 = rsp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_zext = 1'b0; req_addr = 32'h400;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_outputs: got dmem_req=%b ready=%b, required 0 1", dmem_req, req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0; dmem_rdata = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_cnt != c0 || req_ready !== 1'b1 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_late_rvalid: got pulses=%0d ready=%b dmem_req=%b, required 0 1 0",
               rsp_cnt - c0, req_ready, dmem_req);
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_store();
    test_byte_load();
    test_half_load_stall();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
